// File: rtl/ifetch_pkg.sv
// Constants shared by the fetch, decode and EX stages.
package ifetch_pkg;

  localparam int DEF_PC_W = 16;

  localparam logic [3:0] LLB_OPCODE = 4'hB;

  // LLB R0,#0: writes zero to R0. Decode treats it as a bubble.
  localparam logic [31:0] NOP_WORD = {16'h0000, LLB_OPCODE, 12'h000};

  function automatic int occ_width(input int depth);
    return $clog2(depth + 1);
  endfunction

endpackage

// File: rtl/ifetch_queue.sv
// Small circular instruction queue holding {word, pc} entries for the fetch stage.
module ifetch_queue
  import ifetch_pkg::*;
#(
  parameter int DEPTH = 3,
  parameter int W     = 48,
  parameter int OCC_W = occ_width(DEPTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             push,
  input  logic             pop,
  input  logic [W-1:0]     din,
  output logic [OCC_W-1:0] occ,
  output logic [W-1:0]     head
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [W-1:0]     mem [DEPTH];
  logic [PTR_W-1:0] rd_ptr;
  logic [PTR_W-1:0] wr_ptr;
  logic             do_push;
  logic             do_pop;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
  endfunction

  // A push into a full queue only lands if a pop frees the slot in the same cycle.
  always_comb begin
    do_pop  = 1'b0;
    do_push = 1'b0;
    if (!clr) begin
      do_pop  = pop && (occ != '0);
      do_push = push && ((occ != OCC_W'(DEPTH)) || do_pop);
    end
  end

  always_ff @(posedge clk) begin
    if (rst || clr) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      occ    <= '0;
    end else begin
      if (do_push) wr_ptr <= ptr_inc(wr_ptr);
      if (do_pop)  rd_ptr <= ptr_inc(rd_ptr);
      if (do_push && !do_pop)      occ <= occ + OCC_W'(1);
      else if (do_pop && !do_push) occ <= occ - OCC_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= din;
  end

  assign head = mem[rd_ptr];

endmodule

// File: rtl/ifetch.sv
// Instruction fetch: owns the fetch PC, drives the sync-read IM and feeds decode from a queue.
module ifetch
  import ifetch_pkg::*;
#(
  parameter int              PC_W      = DEF_PC_W,
  parameter int              IM_AW     = 14,
  parameter int              QDEPTH    = 3,
  parameter logic [PC_W-1:0] RESET_PC  = '0,
  parameter logic [31:0]     NOP_INSTR = NOP_WORD
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             stall_IM_ID,
  input  logic             stall_ID_EX,
  input  logic             flow_change_ID_EX,
  input  logic [PC_W-1:0]  dst_ID_EX,
  output logic [IM_AW-1:0] im_addr,
  output logic             im_re,
  input  logic [31:0]      im_rd_data,
  output logic [31:0]      instr,
  output logic             instr_vld,
  output logic [PC_W-1:0]  nxt_pc_ID_EX
);

  localparam int OCC_W = occ_width(QDEPTH);
  localparam int ENT_W = 32 + PC_W;

  logic [PC_W-1:0]  f_pc;
  logic [PC_W-1:0]  inflight_pc;
  logic [PC_W-1:0]  nxt_pc_IM_ID;
  logic             inflight;
  logic             squash;
  logic             issue;
  logic             push;
  logic             pop;
  logic [OCC_W-1:0] occ;
  logic [ENT_W-1:0] head;
  logic [31:0]      head_word;
  logic [PC_W-1:0]  head_pc;

  ifetch_queue #(
    .DEPTH (QDEPTH),
    .W     (ENT_W),
    .OCC_W (OCC_W)
  ) u_queue (
    .clk  (clk),
    .rst  (rst),
    .clr  (flow_change_ID_EX),
    .push (push),
    .pop  (pop),
    .din  ({im_rd_data, inflight_pc}),
    .occ  (occ),
    .head (head)
  );

  assign head_word = head[ENT_W-1:PC_W];
  assign head_pc   = head[PC_W-1:0];
  assign instr_vld = (occ != '0);
  assign instr     = instr_vld ? head_word : NOP_INSTR;

  // Redirect wins over everything: the response arriving now is dropped and the queue cleared.
  assign push = inflight && !squash && !flow_change_ID_EX;
  assign pop  = instr_vld && !stall_IM_ID && !flow_change_ID_EX;

  // Credit check uses registered occupancy only, so stall never reaches im_addr/im_re combinationally.
  always_comb begin
    issue = 1'b0;
    if (!flow_change_ID_EX)
      issue = ((OCC_W+1)'(occ) + (OCC_W+1)'(inflight)) < (OCC_W+1)'(QDEPTH);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      f_pc        <= RESET_PC;
      inflight_pc <= '0;
      im_addr     <= '0;
      im_re       <= 1'b0;
      inflight    <= 1'b0;
      squash      <= 1'b0;
    end else if (flow_change_ID_EX) begin
      f_pc     <= dst_ID_EX;
      im_re    <= 1'b0;
      inflight <= 1'b0;
      squash   <= inflight;
    end else if (issue) begin
      f_pc        <= f_pc + PC_W'(1);
      inflight_pc <= f_pc;
      im_addr     <= f_pc[IM_AW-1:0];
      im_re       <= 1'b1;
      inflight    <= 1'b1;
      squash      <= 1'b0;
    end else begin
      im_re    <= 1'b0;
      inflight <= 1'b0;
      squash   <= 1'b0;
    end
  end

  // An empty queue hands decode a zero link value alongside the NOP.
  always_ff @(posedge clk) begin
    if (rst) begin
      nxt_pc_IM_ID <= '0;
      nxt_pc_ID_EX <= '0;
    end else begin
      if (!stall_IM_ID) nxt_pc_IM_ID <= instr_vld ? head_pc + PC_W'(1) : '0;
      if (!stall_ID_EX) nxt_pc_ID_EX <= nxt_pc_IM_ID;
    end
  end

endmodule

// File: tb/tb_ifetch.sv
// Directed bench for ifetch: IM[a] = a, hand-computed expectations per cycle.
module tb_ifetch;

  localparam int PC_W  = 16;
  localparam int IM_AW = 14;
  localparam logic [31:0] NOP = 32'h0000B000;

  logic             clk = 1'b0;
  logic             rst;
  logic             stall_IM_ID;
  logic             stall_ID_EX;
  logic             flow_change_ID_EX;
  logic [PC_W-1:0]  dst_ID_EX;
  logic [IM_AW-1:0] im_addr;
  logic             im_re;
  logic [31:0]      im_rd_data;
  logic [31:0]      instr;
  logic             instr_vld;
  logic [PC_W-1:0]  nxt_pc_ID_EX;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  always #5 clk = ~clk;

  // The registered im_addr stands in for the IM's address register, so data follows it directly.
  assign im_rd_data = im_re ? {18'd0, im_addr} : 32'hDEAD_BEEF;

  ifetch dut (
    .clk               (clk),
    .rst               (rst),
    .stall_IM_ID       (stall_IM_ID),
    .stall_ID_EX       (stall_ID_EX),
    .flow_change_ID_EX (flow_change_ID_EX),
    .dst_ID_EX         (dst_ID_EX),
    .im_addr           (im_addr),
    .im_re             (im_re),
    .im_rd_data        (im_rd_data),
    .instr             (instr),
    .instr_vld         (instr_vld),
    .nxt_pc_ID_EX      (nxt_pc_ID_EX)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s cyc=%0d got=%h exp=%h", tag, cyc, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  initial begin
    rst = 1'b1;
    stall_IM_ID = 1'b0;
    stall_ID_EX = 1'b0;
    flow_change_ID_EX = 1'b0;
    dst_ID_EX = '0;
    repeat (3) tick();
    chk("rst_instr", instr, NOP);
    chk("rst_vld", 32'(instr_vld), 0);
    chk("rst_im_re", 32'(im_re), 0);
    chk("rst_im_addr", 32'(im_addr), 0);
    chk("rst_nxt_pc", 32'(nxt_pc_ID_EX), 0);

    // cycle 0: first cycle with rst low
    rst = 1'b0;
    cyc = 0;
    for (int c = 1; c <= 9; c++) begin
      tick();
      chk("run_im_addr", 32'(im_addr), c - 1);
      chk("run_im_re", 32'(im_re), 1);
      if (c == 1) chk("run_vld0", 32'(instr_vld), 0);
      if (c >= 2) chk("run_instr", instr, c - 2);
      if (c >= 4) chk("run_nxt_pc", 32'(nxt_pc_ID_EX), c - 3);
    end

    // cycle 9: instr = 7, hold decode for cycles 9..13
    stall_IM_ID = 1'b1;
    for (int c = 10; c <= 13; c++) begin
      tick();
      chk("stall_hold", instr, 7);
      chk("stall_im_re", 32'(im_re), (c == 10) ? 1 : 0);
    end
    tick();
    stall_IM_ID = 1'b0;
    for (int c = 14; c <= 17; c++) begin
      if (c > 14) tick();
      chk("release_seq", instr, c - 7);
    end

    // cycle 17: redirect while word 11 is in flight
    flow_change_ID_EX = 1'b1;
    dst_ID_EX = 16'h0040;
    tick();
    flow_change_ID_EX = 1'b0;
    chk("redir_nop0", instr, NOP);
    chk("redir_vld0", 32'(instr_vld), 0);
    chk("redir_no_issue", 32'(im_re), 0);
    tick();
    chk("redir_nop1", instr, NOP);
    chk("redir_vld1", 32'(instr_vld), 0);
    chk("redir_tgt_addr", 32'(im_addr), 32'h40);
    tick();
    chk("redir_tgt", instr, 32'h40);
    tick();
    chk("redir_tgt_next", instr, 32'h41);

    // cycle 21: fill the queue, then redirect under stall at cycle 24
    stall_IM_ID = 1'b1;
    repeat (3) tick();
    chk("full_hold", instr, 32'h41);
    chk("full_idle", 32'(im_re), 0);
    flow_change_ID_EX = 1'b1;
    dst_ID_EX = 16'h0080;
    tick();
    flow_change_ID_EX = 1'b0;
    chk("rs_clear", instr, NOP);
    chk("rs_vld", 32'(instr_vld), 0);
    tick();
    chk("rs_fetch_addr", 32'(im_addr), 32'h80);
    chk("rs_fetch_re", 32'(im_re), 1);
    tick();
    chk("rs_head", instr, 32'h80);
    tick();
    stall_IM_ID = 1'b0;
    for (int c = 28; c <= 31; c++) begin
      if (c > 28) tick();
      chk("rs_seq", instr, 32'h80 + c - 28);
    end

    // cycle 31: redirect near the top of the PC space
    flow_change_ID_EX = 1'b1;
    dst_ID_EX = 16'hFFFE;
    tick();
    flow_change_ID_EX = 1'b0;
    chk("wrap_nop", instr, NOP);
    tick();
    chk("wrap_addr_fffe", 32'(im_addr), 32'h3FFE);
    tick();
    chk("wrap_addr_ffff", 32'(im_addr), 32'h3FFF);
    chk("wrap_instr_fffe", instr, 32'h3FFE);
    tick();
    chk("wrap_addr_0", 32'(im_addr), 0);
    chk("wrap_instr_ffff", instr, 32'h3FFF);
    tick();
    chk("wrap_instr_0", instr, 0);
    chk("wrap_nxt_fffe", 32'(nxt_pc_ID_EX), 32'hFFFF);
    tick();
    chk("wrap_nxt_ffff", 32'(nxt_pc_ID_EX), 0);
    tick();
    chk("wrap_nxt_0", 32'(nxt_pc_ID_EX), 1);
    stall_ID_EX = 1'b1;
    tick();
    stall_ID_EX = 1'b0;
    chk("idex_hold", 32'(nxt_pc_ID_EX), 1);
    tick();
    chk("idex_resume", 32'(nxt_pc_ID_EX), 3);

    // cycle 40: stall until full, reset pulse in cycle 43
    chk("pre_rst_instr", instr, 4);
    stall_IM_ID = 1'b1;
    repeat (3) tick();
    chk("pre_rst_hold", instr, 4);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    stall_IM_ID = 1'b0;
    chk("mid_rst_instr", instr, NOP);
    chk("mid_rst_vld", 32'(instr_vld), 0);
    chk("mid_rst_im_re", 32'(im_re), 0);
    chk("mid_rst_nxt_pc", 32'(nxt_pc_ID_EX), 0);
    tick();
    chk("restart_addr", 32'(im_addr), 0);
    chk("restart_re", 32'(im_re), 1);
    chk("restart_vld", 32'(instr_vld), 0);
    tick();
    chk("restart_instr0", instr, 0);
    tick();
    chk("restart_instr1", instr, 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
